// File: rtl/opu_pipe.sv
// rtl/opu_pipe.sv - buffered operation unit: request FIFO, registered ALU stage, held result register
module opu_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(WIDTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_start,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [AW-1:0]    op_amt,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             op_done,
    input  logic             out_ready,
    output logic [LW-1:0]    fifo_level
);

    localparam int PW = $clog2(DEPTH);

    logic [2:0]       q_code [DEPTH];
    logic [AW-1:0]    q_amt  [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] acc;

    logic             push;
    logic             pop;
    logic [2:0]       h_code;
    logic [AW-1:0]    h_amt;
    logic [WIDTH-1:0] h_data;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] rev;
    logic [AW:0]      inv_amt;
    logic [WIDTH-1:0] alu;

    // op_ready looks only at the stored level, so a full FIFO never accepts
    // a request even when the head is leaving in the same cycle.
    assign op_ready   = (level != LW'(DEPTH));
    assign fifo_level = level;
    assign push       = op_start && op_ready;
    assign pop        = (level != '0) && (!op_done || out_ready);

    assign h_code = q_code[rd_ptr];
    assign h_amt  = q_amt[rd_ptr];
    assign h_data = q_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_code[wr_ptr] <= op_code;
            q_amt[wr_ptr]  <= op_amt;
            q_data[wr_ptr] <= data_in;
        end
    end

    // Rotates use a complementary shift of WIDTH-s; at s=0 that shift clears
    // the second term, so the operand passes through unchanged.
    always_comb begin
        acc_sum = acc + h_data;
        inv_amt = (AW+1)'(WIDTH) - {1'b0, h_amt};
        rev     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = h_data[WIDTH-1-i];
        end
        case (h_code)
            3'b000:  alu = h_data;
            3'b001:  alu = h_data << h_amt;
            3'b010:  alu = (h_data >> h_amt) | (h_data << inv_amt);
            3'b011:  alu = ~h_data;
            3'b100:  alu = h_data >> h_amt;
            3'b101:  alu = (h_data << h_amt) | (h_data >> inv_amt);
            3'b110:  alu = rev;
            default: alu = acc_sum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            acc      <= '0;
            data_out <= '0;
            op_done  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                data_out <= alu;
                op_done  <= 1'b1;
                // The accumulator advances when the op executes, not when queued.
                if (h_code == 3'b111) begin
                    acc <= acc_sum;
                end
            end else if (out_ready) begin
                op_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opu_pipe.sv
// tb/tb_opu_pipe.sv - self-checking bench for opu_pipe (WIDTH=8, DEPTH=4)
module tb_opu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_start;
    logic       op_ready;
    logic [2:0] op_code;
    logic [2:0] op_amt;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       op_done;
    logic       out_ready;
    logic [3:0] fifo_level;

    int tests = 0;
    int fails = 0;
    int n_consumed = 0;
    int m_acc = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [2:0] code;
        logic [2:0] amt;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    opu_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_start   (op_start),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_amt     (op_amt),
        .data_in    (data_in),
        .data_out   (data_out),
        .op_done    (op_done),
        .out_ready  (out_ready),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bit-level definitions with integer arithmetic.
    function automatic logic [7:0] model_op(input logic [2:0] c, input logic [2:0] a, input logic [7:0] d);
        int v;
        int s;
        int r;
        v = int'(d);
        s = int'(a);
        r = 0;
        case (c)
            3'd0: r = v;
            3'd1: r = (v * (1 << s)) % 256;
            3'd2: for (int i = 0; i < 8; i++) if (((v >> ((i + s) % 8)) & 1) == 1) r += (1 << i);
            3'd3: r = 255 - v;
            3'd4: r = v / (1 << s);
            3'd5: for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) r += (1 << ((i + s) % 8));
            3'd6: for (int i = 0; i < 8; i++) if (((v >> i) & 1) == 1) r += (1 << (7 - i));
            default: begin
                m_acc = (m_acc + v) % 256;
                r = m_acc;
            end
        endcase
        return 8'(r);
    endfunction

    // Scoreboard: every consumed result must match the model in request order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_acc = 0;
        end else begin
            if (op_done && out_ready) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: unexpected result 0x%0h with nothing outstanding", data_out);
                end else begin
                    check("scoreboard", data_out, exp_q.pop_front());
                end
            end
            if (op_start && op_ready) begin
                exp_q.push_back(model_op(op_code, op_amt, data_in));
            end
        end
    end

    task automatic send_one(input logic [2:0] c, input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
        op_code  = c;
        op_amt   = a;
        data_in  = d;
        op_start = 1'b1;
        @(negedge clk);
        check("single_accept", op_ready, 1);
        tick();
        op_start = 1'b0;
        @(negedge clk);
        check("latency_n1_idle", op_done, 0);
        tick();
        @(negedge clk);
        check("latency_n2_done", op_done, 1);
        check("single_result", data_out, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lvl_bad;
        int nacc;
        int base;
        int cnt;
        logic [7:0] held;
        logic [31:0] seq;
        logic [2:0] bp_code[6];
        logic [2:0] bp_amt[6];
        logic [7:0] bp_data[6];

        vecs[0] = '{3'b010, 3'd2, 8'hB4, 8'h2D};
        vecs[1] = '{3'b001, 3'd3, 8'h81, 8'h08};
        vecs[2] = '{3'b011, 3'd0, 8'h5A, 8'hA5};
        vecs[3] = '{3'b110, 3'd0, 8'h01, 8'h80};
        vecs[4] = '{3'b101, 3'd1, 8'h80, 8'h01};
        vecs[5] = '{3'b100, 3'd7, 8'hFF, 8'h01};
        vecs[6] = '{3'b111, 3'd0, 8'hF0, 8'hF0};
        vecs[7] = '{3'b111, 3'd0, 8'h20, 8'h10};

        rst = 1'b1; op_start = 1'b0; op_code = '0; op_amt = '0; data_in = '0; out_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("reset_data_out", data_out, 0);
        check("reset_op_done", op_done, 0);
        check("reset_fifo_level", fifo_level, 0);
        check("reset_op_ready", op_ready, 1);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i].code, vecs[i].amt, vecs[i].din, vecs[i].exp);
        end
        // s=0 passes the operand through for every shift/rotate
        send_one(3'b010, 3'd0, 8'h9C, 8'h9C);
        send_one(3'b101, 3'd0, 8'h9C, 8'h9C);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_one(3'b111, 3'd0, 8'h05, 8'h05);

        // Backpressure and full-boundary
        for (int i = 0; i < 6; i++) begin
            bp_code[i] = 3'($urandom);
            bp_amt[i]  = 3'($urandom);
            bp_data[i] = 8'($urandom);
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            if (k < 6) begin
                op_start = 1'b1; op_code = bp_code[k]; op_amt = bp_amt[k]; data_in = bp_data[k];
            end
            @(negedge clk);
            if (op_start && op_ready) k++;
            tick();
        end
        @(negedge clk);
        check("bp_accepted", k, 5);
        check("bp_level_full", fifo_level, 4);
        check("bp_op_ready_low", op_ready, 0);
        check("bp_op_done", op_done, 1);
        held = data_out;
        repeat (2) tick();
        @(negedge clk);
        check("bp_data_stable", data_out, held);
        tick();
        out_ready = 1'b1;
        base = n_consumed;
        @(negedge clk);
        check("full_pop_ready_still_low", op_ready, 0);
        check("full_pop_done", op_done, 1);
        tick();
        @(negedge clk);
        check("full_pop_level", fifo_level, 3);
        check("full_pop_ready_rises", op_ready, 1);
        check("full_pop_done2", op_done, 1);
        if (op_start && op_ready) k++;
        tick();
        op_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("bp_drain_consecutive", op_done, 1);
            tick();
        end
        @(negedge clk);
        check("bp_drain_done_low", op_done, 0);
        check("bp_all_six", n_consumed - base, 6);
        check("bp_sixth_accepted", k, 6);
        tick();

        // Streaming
        lvl_bad = 0; nacc = 0; seq = '0;
        for (int c = 0; c < 30; c++) begin
            op_start = (c < 16);
            op_code = 3'($urandom); op_amt = 3'($urandom); data_in = 8'($urandom);
            @(negedge clk);
            seq[c] = op_done;
            if (fifo_level > 1) lvl_bad++;
            if (c < 16 && !op_ready) nacc++;
            tick();
        end
        op_start = 1'b0;
        check("stream_level_le1", lvl_bad, 0);
        check("stream_all_accepted", nacc, 0);
        check("stream_done_count", $countones(seq), 16);
        check("stream_done_window", seq[17:2], 16'hFFFF);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            op_start = 1'b1; op_code = 3'b111; op_amt = '0; data_in = 8'($urandom_range(1, 255));
            tick();
        end
        op_start = 1'b0;
        @(negedge clk);
        check("midrst_pre_done", op_done, 1);
        check("midrst_pre_level", fifo_level, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_done", op_done, 0);
        check("midrst_level", fifo_level, 0);
        check("midrst_data", data_out, 0);
        base = n_consumed;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            @(negedge clk);
            if (op_done) cnt++;
        end
        check("midrst_no_stale_done", cnt, 0);
        check("midrst_no_stale_consumed", n_consumed - base, 0);
        tick();
        send_one(3'b111, 3'd0, 8'h07, 8'h07);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 400; c++) begin
            op_start  = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            op_code   = 3'($urandom);
            op_amt    = 3'($urandom);
            data_in   = 8'($urandom);
            @(negedge clk);
            if (fifo_level > 4) begin
                tests++; fails++;
                $display("FAIL rand_level_bound: got %0d expected <= 4", fifo_level);
            end
            tick();
        end
        op_start = 1'b0;
        out_ready = 1'b1;
        cnt = 0;
        while ((exp_q.size() != 0 || op_done) && cnt < 20) begin
            tick();
            cnt++;
        end
        @(negedge clk);
        check("rand_drain_timeout", (cnt < 20), 1);
        check("rand_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/opu_pipe.md
Name: opu_pipe

Overview:
Parametrised, buffered successor of the single-shot 8-bit operation unit. Requests (opcode, shift amount, operand) arrive over a valid/ready handshake and queue in an internal FIFO. They execute in order through a registered ALU stage that supports a variable shift amount and a stateful accumulate op. Results leave through a valid/ready output register with backpressure. The block sits between the user request interface and the server response path.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of 2, at least 4.
DEPTH, 4, request FIFO entries; must be a power of 2, at least 2.
AW, $clog2(WIDTH), shift-amount width (derived, not overridden).
LW, $clog2(DEPTH)+1, FIFO level width (derived).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
op_start  input  1  request valid
op_ready  output  1  request accepted when op_start && op_ready
op_code  input  3  operation select
op_amt  input  AW  shift/rotate amount
data_in  input  WIDTH  operand
data_out  output  WIDTH  result
op_done  output  1  result valid; held until consumed
out_ready  input  1  consumer accepts result when op_done && out_ready
fifo_level  output  LW  entries currently queued (0..DEPTH)

Behaviour:
- Reset (clk edge with rst=1):
  - data_out=0, op_done=0, fifo_level=0.
  - Accumulator=0, FIFO pointers=0.
  - Reset mid-operation discards every queued and in-flight request; no op_done follows.
- op_ready = (fifo_level != DEPTH). It does not depend on the same-cycle pop; a full FIFO never does pass-through writes.
- Push: op_start && op_ready writes {op_code, op_amt, data_in} at the tail.
- Pop: when FIFO is non-empty and (op_done==0 || out_ready==1):
  - head executes; result loads into data_out.
  - op_done=1 the next cycle.
- Result register:
  - op_done && out_ready && FIFO empty → op_done=0.
  - op_done && !out_ready → data_out and op_done hold; no pop.
- Simultaneous push and pop: fifo_level unchanged. Pointers wrap modulo DEPTH.
- Latency: request accepted in cycle N with empty FIFO and free output → op_done=1 with result in cycle N+2.
- Throughput: one result per cycle under continuous out_ready=1.
- Ordering: strict FIFO; results in request order.
- Opcodes (s = op_amt, arithmetic mod 2^WIDTH):
  - 000 pass: data_in
  - 001 logical shift left by s, zero fill
  - 010 rotate right by s
  - 011 bitwise invert
  - 100 logical shift right by s, zero fill
  - 101 rotate left by s
  - 110 bit reverse (bit i → bit WIDTH-1-i)
  - 111 accumulate: acc_next = acc + data_in; data_out = acc_next; acc updated at execution, not at acceptance
- s=0 for any shift/rotate returns data_in unchanged. op_amt is ignored for opcodes 000, 011, 110, 111.
- The accumulator is changed only by opcode 111 and by reset.

Test Plan:
1. WIDTH=8. Reset, then single requests with out_ready=1:
   - 010 amt2 0xB4 → 0x2D
   - 001 amt3 0x81 → 0x08
   - 011 0x5A → 0xA5
   - 110 0x01 → 0x80
   - 101 amt1 0x80 → 0x01
   - 100 amt7 0xFF → 0x01
   - each op_done exactly 2 cycles after acceptance.
2. Accumulate wrap: 111 0xF0, then 111 0x20 → data_out 0xF0, then 0x10. Reset, then 111 0x05 → 0x05.
3. Backpressure, DEPTH=4, out_ready=0, 6 back-to-back requests:
   - 5 accepted (1 in output register, 4 queued); fifo_level=4; op_ready=0; 6th held.
   - data_out stable.
   - then out_ready=1 → 6 results in order on consecutive cycles; op_ready rises the cycle after the first pop.
4. Streaming: 16 back-to-back requests with out_ready=1 → 16 consecutive op_done cycles; fifo_level never exceeds 1.
5. Reset mid-stream: assert rst with 3 queued and op_done=1 → next cycle op_done=0, fifo_level=0, data_out=0, acc=0; none of the discarded results ever appears.
6. Full boundary: fifo_level=DEPTH with out_ready=1 and op_start=1 in the same cycle → pop occurs, push rejected, fifo_level=DEPTH-1; request accepted on the next cycle.
